hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller that drives the stall, flush and forwarding controls around the decode/execute boundary. It produces the CLR input of the execute-stage register, the bypass selects for the execute and decode stages, and the hold signals for fetch, decode and execute. It also sequences multi-cycle multiply/divide ops that occupy the execute stage, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MDU_LAT, 4: total cycles a MUL/DIV op stays in execute; must be ≥1 (1 = no MDU stall)
- MUL_CODE, 5'b01100: aluControlE encoding of multiply
- DIV_CODE, 5'b01101: aluControlE encoding of divide

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- rsD, rtD  in  5  source register numbers in decode
- branchD  in  1  decode holds a branch that compares registers
- pcSrcD  in  1  branch/jump taken, resolved in decode
- rsE, rtE  in  5  source register numbers in execute
- writeRegE  in  5  destination register in execute
- regWriteE, memToRegE  in  1  execute-stage write enable and load flag
- aluControlE  in  5  execute-stage ALU op
- writeRegM  in  5  destination register in memory stage
- regWriteM, memToRegM  in  1  memory-stage write enable and load flag
- writeRegW  in  5  destination register in writeback
- regWriteW  in  1  writeback write enable
- stallF, stallD, stallE  out  1  hold PC, decode register, execute register
- flushD  out  1  clear decode register
- flushE  out  1  CLR of execute register
- flushM  out  1  clear memory-stage register (bubble)
- forwardAE, forwardBE  out  2  execute operand select: 00 reg file, 01 writeback result, 10 memory-stage ALU result
- forwardAD, forwardBD  out  1  decode comparator bypass from memory-stage ALU result
- mduBusy  out  1  MDU FSM in BUSY
- stallCount  out  16  saturating count of cycles with stallF=1

## Operation
- Register 0 never matches: every register comparison also requires the compared number ≠ 0.
- forwardAE: 10 if regWriteM and writeRegM==rsE; else 01 if regWriteW and writeRegW==rsE; else 00. forwardBE: same rules using rtE. The memory stage has priority.
- forwardAD = regWriteM and writeRegM==rsD. forwardBD = same with rtD.
- lwStall = memToRegE and (writeRegE==rsD or writeRegE==rtD).
- brStall = branchD and ((regWriteE and writeRegE∈{rsD,rtD}) or (memToRegM and writeRegM∈{rsD,rtD})).
- mduStall: asserted while the MDU FSM holds an op (see below).
- stallF = stallD = lwStall or brStall or mduStall.
- stallE = mduStall.
- flushE = (lwStall or brStall) and not mduStall. The execute register must hold during an MDU stall, never clear.
- flushM = mduStall.
- flushD = pcSrcD and not stallD.
- MDU FSM states are IDLE and BUSY, with a counter cnt of width clog2(MDU_LAT)+1.
  - IDLE: if MDU_LAT>1 and aluControlE∈{MUL_CODE,DIV_CODE}, then mduStall=1 combinationally, load cnt=MDU_LAT-1, and go to BUSY. Otherwise mduStall=0.
  - BUSY: mduStall = (cnt>1). If cnt>1, cnt decrements. If cnt==1, mduStall=0 and the next state is IDLE.
  - While in BUSY, aluControlE is not re-sampled. A MUL/DIV arriving immediately after release is a new op and is detected in IDLE.
- stallCount increments on each rising edge where stallF=1 and stops at 16'hFFFF.

## Timing
- Reset (RST low, any time including mid-BUSY): the FSM goes to IDLE immediately, cnt=0, stallCount=0, mduBusy=0, mduStall=0. Combinational outputs then follow the IDLE equations for the current inputs.
- The forwarding, lwStall, brStall and flushD outputs are purely combinational with zero latency.
- A MUL/DIV entering execute stays there exactly MDU_LAT cycles:
  - mduStall is high for the first MDU_LAT-1 of those cycles and low in the last.
  - mduBusy is high for cycles 2..MDU_LAT.
- Simultaneous events:
  - MDU stall and load-use together: stallF/D/E=1, flushE=0, flushM=1. lwStall is re-evaluated after release.
  - stallD=1 and pcSrcD=1 together: flushD=0, so the branch is retried.

## Test plan
- Forwarding: regWriteM=1, writeRegM=5, rsE=5, regWriteW=1, writeRegW=5 -> forwardAE=10. Then set regWriteM=0 -> forwardAE=01. Set writeRegM=writeRegW=rsE=0 -> forwardAE=00.
- Load-use: memToRegE=1, writeRegE=7, rtD=7 -> stallF=stallD=flushE=1, stallE=0 in the same cycle. Next cycle with memToRegE=0 -> all deasserted. stallCount=1.
- MDU, MDU_LAT=4: aluControlE=MUL_CODE at cycle 0 -> stallF/D/E=flushM=1 in cycles 0-2, mduBusy=1 in cycles 1-3, all stalls 0 in cycle 3, FSM in IDLE at cycle 4.
- Back-to-back MUL then DIV: second op detected at cycle 4 -> stalls in cycles 4-6. stallCount=6 after cycle 7.
- Reset mid-BUSY: RST low at cycle 1 of a MUL -> mduBusy and stallE drop asynchronously and stallCount=0. After RST release with aluControlE=ADD, no stall.
- Branch: branchD=1, regWriteE=1, writeRegE=3, rsD=3, pcSrcD=1 -> stallD=1, flushE=1, flushD=0. With writeRegE=4 -> stallD=0, flushD=1.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit
//   Stall / flush / bypass controller around the decode-execute boundary.
//   Also sequences multi-cycle MUL/DIV ops held in execute and counts
//   stalled fetch cycles.
//
// Ports
//   CLK, RST                     clock (rising), async active-low reset
//   rsD, rtD, branchD, pcSrcD    decode-stage sources, branch info
//   rsE, rtE, writeRegE,
//   regWriteE, memToRegE,
//   aluControlE                  execute-stage operands / destination / op
//   writeRegM, regWriteM,
//   memToRegM                    memory-stage destination info
//   writeRegW, regWriteW         writeback destination info
//   stallF/D/E                   hold PC, decode reg, execute reg
//   flushD/E/M                   clear decode reg, execute reg (CLR), mem reg
//   forwardAE/BE                 00 regfile, 01 writeback, 10 mem-stage ALU
//   forwardAD/BD                 decode comparator bypass from mem stage
//   mduBusy                      MDU sequencer in BUSY
//   stallCount                   saturating count of stallF cycles
module hazard_unit #(
    parameter int         MDU_LAT  = 4,
    parameter logic [4:0] MUL_CODE = 5'b01100,
    parameter logic [4:0] DIV_CODE = 5'b01101
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        branchD,
    input  logic        pcSrcD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeRegE,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic [4:0]  aluControlE,
    input  logic [4:0]  writeRegM,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic [4:0]  writeRegW,
    input  logic        regWriteW,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic        mduBusy,
    output logic [15:0] stallCount
);

    localparam int              CW     = $clog2(MDU_LAT) + 1;
    localparam logic [CW-1:0]   CNT_LD = CW'(MDU_LAT - 1);
    localparam logic [CW-1:0]   CNT_1  = CW'(1);

    typedef enum logic {IDLE, BUSY} mdu_st_t;

    mdu_st_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic          mdu_stall, lw_stall, br_stall, hz_stall, mdu_op;

    // Register 0 is hard-wired, so a match on it is never a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (b != 5'd0);
    endfunction

    // ---------------- bypass selects ----------------
    always_comb begin
        forwardAE = 2'b00;
        if (regWriteM && hit(writeRegM, rsE))      forwardAE = 2'b10;
        else if (regWriteW && hit(writeRegW, rsE)) forwardAE = 2'b01;
        forwardBE = 2'b00;
        if (regWriteM && hit(writeRegM, rtE))      forwardBE = 2'b10;
        else if (regWriteW && hit(writeRegW, rtE)) forwardBE = 2'b01;
    end

    assign forwardAD = regWriteM && hit(writeRegM, rsD);
    assign forwardBD = regWriteM && hit(writeRegM, rtD);

    // ---------------- data hazards ----------------
    assign lw_stall = memToRegE && (hit(writeRegE, rsD) || hit(writeRegE, rtD));
    assign br_stall = branchD &&
        ((regWriteE && (hit(writeRegE, rsD) || hit(writeRegE, rtD))) ||
         (memToRegM && (hit(writeRegM, rsD) || hit(writeRegM, rtD))));

    // ---------------- MDU sequencer ----------------
    assign mdu_op = (aluControlE == MUL_CODE) || (aluControlE == DIV_CODE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by RST so the stall also drops while reset is held.
                if ((MDU_LAT > 1) && mdu_op && RST) begin
                    mdu_stall = 1'b1;
                    cnt_d     = CNT_LD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Final cycle (cnt==1) releases the stall while still BUSY.
                if (cnt_q > CNT_1) begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_1;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- stall / flush ----------------
    assign hz_stall = lw_stall || br_stall;
    assign stallF   = hz_stall || mdu_stall;
    assign stallD   = stallF;
    assign stallE   = mdu_stall;
    // Execute register must hold, not clear, while an MDU op occupies it.
    assign flushE   = hz_stall && !mdu_stall;
    assign flushM   = mdu_stall;
    // A stalled decode retries the branch, so do not squash it.
    assign flushD   = pcSrcD && !stallD;
    assign mduBusy  = (state_q == BUSY);

    // ---------------- stall counter ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam logic [4:0] MUL = 5'b01100;
    localparam logic [4:0] DIV = 5'b01101;
    localparam logic [4:0] ADD = 5'b00010;

    logic       CLK = 1'b0, RST = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, aluControlE, writeRegM, writeRegW;
    logic       branchD, pcSrcD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, forwardAD, forwardBD, mduBusy;
    logic [1:0] forwardAE, forwardBE;
    logic [15:0] stallCount;

    int total = 0;
    int bad   = 0;

    hazard_unit #(.MDU_LAT(4), .MUL_CODE(MUL), .DIV_CODE(DIV)) dut (
        .CLK(CLK), .RST(RST),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .pcSrcD(pcSrcD),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
        .memToRegE(memToRegE), .aluControlE(aluControlE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .memToRegM(memToRegM),
        .writeRegW(writeRegW), .regWriteW(regWriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .mduBusy(mduBusy), .stallCount(stallCount)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        rsD = 0; rtD = 0; branchD = 0; pcSrcD = 0;
        rsE = 0; rtE = 0; writeRegE = 0; regWriteE = 0; memToRegE = 0;
        aluControlE = ADD;
        writeRegM = 0; regWriteM = 0; memToRegM = 0;
        writeRegW = 0; regWriteW = 0;
    endtask

    // Leaves the bench 1 time unit after a rising edge, start of a fresh cycle.
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge CLK); RST = 0; #2; RST = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 0; #2;
        total++;
        if ({stallF, stallD, stallE, flushE, flushM, mduBusy} !== 6'b0 || stallCount !== 16'd0) begin
            bad++;
            $display("FAIL reset: ctl=%b cnt=%0d want ctl=000000 cnt=0",
                     {stallF, stallD, stallE, flushE, flushM, mduBusy}, stallCount);
        end
        RST = 1;
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        regWriteM = 1; writeRegM = 5; rsE = 5; regWriteW = 1; writeRegW = 5; #1;
        total++;
        if (forwardAE !== 2'b10) begin bad++; $display("FAIL fwdAE_mem: got %b want 10", forwardAE); end
        regWriteM = 0; #1;
        total++;
        if (forwardAE !== 2'b01) begin bad++; $display("FAIL fwdAE_wb: got %b want 01", forwardAE); end
        regWriteM = 1; writeRegM = 0; writeRegW = 0; rsE = 0; #1;
        total++;
        if (forwardAE !== 2'b00) begin bad++; $display("FAIL fwdAE_r0: got %b want 00", forwardAE); end
        // B side and decode bypass: rtE from writeback, rsD/rtD from mem stage
        writeRegM = 9; writeRegW = 6; rtE = 6; rsD = 9; rtD = 9; #1;
        total++;
        if ({forwardBE, forwardAD, forwardBD} !== 4'b0111) begin
            bad++; $display("FAIL fwd_b_dec: got %b want 0111", {forwardBE, forwardAD, forwardBD});
        end
        rtE = 9; rtD = 3; #1;
        total++;
        if ({forwardBE, forwardAD, forwardBD} !== 4'b1010) begin
            bad++; $display("FAIL fwdBE_mem: got %b want 1010", {forwardBE, forwardAD, forwardBD});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        memToRegE = 1; writeRegE = 7; rtD = 7; #1;
        total++;
        if ({stallF, stallD, flushE, stallE, flushM} !== 5'b11100) begin
            bad++; $display("FAIL lw_stall: got %b want 11100", {stallF, stallD, flushE, stallE, flushM});
        end
        tick();
        memToRegE = 0; #1;
        total++;
        if ({stallF, stallD, flushE, stallE, flushM} !== 5'b00000 || stallCount !== 16'd1) begin
            bad++; $display("FAIL lw_release: got %b cnt=%0d want 00000 cnt=1",
                            {stallF, stallD, flushE, stallE, flushM}, stallCount);
        end
        // writeRegE = 0 never creates a load-use hazard
        memToRegE = 1; writeRegE = 0; rtD = 0; #1;
        total++;
        if (stallF !== 1'b0) begin bad++; $display("FAIL lw_r0: got %b want 0", stallF); end
    endtask

    task automatic test_mdu();
        logic st, bz;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            aluControlE = (c < 4) ? MUL : ADD;
            // load-use arrives during the stall: execute reg must hold, not clear
            memToRegE = (c == 1 || c == 2); writeRegE = 7; rtD = 7;
            #1;
            st = (c < 3); bz = (c >= 1 && c <= 3);
            total++;
            if ({stallF, stallD, stallE, flushM, flushE, mduBusy} !== {st, st, st, st, 1'b0, bz}) begin
                bad++; $display("FAIL mdu_c%0d: got %b want %b", c,
                                {stallF, stallD, stallE, flushM, flushE, mduBusy}, {st, st, st, st, 1'b0, bz});
            end
            tick();
        end
        memToRegE = 0;
    endtask

    task automatic test_back_to_back();
        logic st;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            aluControlE = (c < 4) ? MUL : (c < 8) ? DIV : ADD;
            #1;
            st = (c != 3 && c < 7);
            total++;
            if ({stallF, stallE, flushM} !== {st, st, st}) begin
                bad++; $display("FAIL b2b_c%0d: got %b want %b", c, {stallF, stallE, flushM}, {st, st, st});
            end
            if (c == 8) begin
                total++;
                if (stallCount !== 16'd6 || mduBusy !== 1'b0) begin
                    bad++; $display("FAIL b2b_count: got cnt=%0d busy=%b want cnt=6 busy=0", stallCount, mduBusy);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        aluControlE = MUL; #1;
        tick();
        total++;
        if ({mduBusy, stallE} !== 2'b11) begin bad++; $display("FAIL rmb_pre: got %b want 11", {mduBusy, stallE}); end
        #2; RST = 0; #1;
        total++;
        if ({mduBusy, stallE} !== 2'b00 || stallCount !== 16'd0) begin
            bad++; $display("FAIL rmb_async: got %b cnt=%0d want 00 cnt=0", {mduBusy, stallE}, stallCount);
        end
        aluControlE = ADD;
        @(negedge CLK); RST = 1;
        tick();
        total++;
        if ({stallF, stallE, mduBusy} !== 3'b000 || stallCount !== 16'd0) begin
            bad++; $display("FAIL rmb_after: got %b cnt=%0d want 000 cnt=0", {stallF, stallE, mduBusy}, stallCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branchD = 1; regWriteE = 1; writeRegE = 3; rsD = 3; pcSrcD = 1; #1;
        total++;
        if ({stallD, flushE, flushD} !== 3'b110) begin
            bad++; $display("FAIL br_stall: got %b want 110", {stallD, flushE, flushD});
        end
        writeRegE = 4; #1;
        total++;
        if ({stallD, flushE, flushD} !== 3'b001) begin
            bad++; $display("FAIL br_go: got %b want 001", {stallD, flushE, flushD});
        end
        memToRegM = 1; writeRegM = 9; rtD = 9; #1;
        total++;
        if ({stallD, flushE, flushD} !== 3'b110) begin
            bad++; $display("FAIL br_memld: got %b want 110", {stallD, flushE, flushD});
        end
        memToRegM = 0; branchD = 0; regWriteE = 1; writeRegE = 3; rsD = 3; #1;
        total++;
        if ({stallD, flushD} !== 2'b01) begin
            bad++; $display("FAIL br_nobranch: got %b want 01", {stallD, flushD});
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_back_to_back();
        test_reset_mid_busy();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
